pipe_hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage RV32I core.
- Sits beside the ID/EX boundary, directly upstream of the EX-stage forwarding unit.
- Decides when the ID instruction may advance into EX: inserts a load-use bubble, flushes on taken branches/jumps, and freezes the pipe during data-memory wait states.
- Guarantees that every RAW dependency reaching EX is resolvable by the EX forwarding paths. Also holds the pipe for a fixed period after reset and keeps saturating performance counters.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/hz_sat_counter.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Opcode map, NOP encoding and hazard FSM states, shared by the ID/EX-side control units.
package pipe_pkg;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_L     = 5'b00000;
  localparam logic [4:0] OP_S     = 5'b01000;
  localparam logic [4:0] OP_B     = 5'b11000;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_MEM_WAIT} hz_state_e;

  function automatic logic uses_rs1(input logic [4:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_B) ||
           (op == OP_I) || (op == OP_L) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [4:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_B);
  endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating event counter; clear wins over increment.
module hz_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_inc && ~&r_cnt) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID/EX hazard controller: post-reset hold, load-use bubble, branch flush,
// data-memory freeze, plus saturating perf counters and a sticky wait timeout.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RST_HOLD    = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [14:0]      inst_ID,
  input  logic [9:0]       inst_EX,
  input  logic             br_taken_EX,
  input  logic             dmem_req_MA,
  input  logic             dmem_ready,
  input  logic             clr_cnt,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             flush_ID,
  output logic             bubble_EX,
  output logic             stall_EX,
  output logic             stall_MA,
  output logic             bubble_WB,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] br_flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

  hz_state_e      r_state;
  logic [HW-1:0]  r_hold;
  logic [WW-1:0]  r_wait;
  logic           r_timeout;

  logic [4:0] w_op_id, w_rs1_id, w_rs2_id, w_op_ex, w_rd_ex;
  logic       w_hold, w_freeze, w_br, w_lu_hit, w_lu;

  assign {w_rs2_id, w_rs1_id, w_op_id} = inst_ID;
  assign {w_rd_ex, w_op_ex}            = inst_EX;

  assign w_lu_hit = (w_op_ex == OP_L) && (w_rd_ex != 5'd0) &&
                    ((uses_rs1(w_op_id) && (w_rs1_id == w_rd_ex)) ||
                     (uses_rs2(w_op_id) && (w_rs2_id == w_rd_ex)));

  // A frozen pipe holds EX, so branch/load-use are re-evaluated after release.
  assign w_hold   = (r_state == ST_HOLD);
  assign w_freeze = ~w_hold & dmem_req_MA & ~dmem_ready;
  assign w_br     = ~w_hold & ~w_freeze & br_taken_EX;
  assign w_lu     = ~w_hold & ~w_freeze & ~br_taken_EX & w_lu_hit;

  assign stall_IF  = w_hold | w_freeze | w_lu;
  assign stall_ID  = w_freeze | w_lu;
  assign flush_ID  = w_hold | w_br;
  assign bubble_EX = w_hold | w_br | w_lu;
  assign stall_EX  = w_freeze;
  assign stall_MA  = w_freeze;
  assign bubble_WB = w_freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HOLD;
      r_hold    <= HW'(RST_HOLD - 1);
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold == '0) r_state <= ST_RUN;
          else              r_hold  <= r_hold - 1'b1;
        end
        default: begin
          if (w_freeze) begin
            r_state <= ST_MEM_WAIT;
            if (r_wait != WAIT_MAX) r_wait <= r_wait + 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_wait  <= '0;
          end
        end
      endcase
      // Flag when this freeze cycle brings the wait count to MEM_TIMEOUT.
      if (clr_cnt)
        r_timeout <= 1'b0;
      else if (w_freeze && (r_wait >= WAIT_MAX - 1'b1))
        r_timeout <= 1'b1;
    end
  end

  assign mem_timeout = r_timeout;

  hz_sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_lu), .i_clr(clr_cnt), .o_cnt(lu_stall_cnt));
  hz_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_br), .i_clr(clr_cnt), .o_cnt(br_flush_cnt));
  hz_sat_counter #(.CNT_W(CNT_W)) u_mw_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_freeze), .i_clr(clr_cnt), .o_cnt(mem_wait_cnt));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vectors for pipe_hazard_ctrl; expectations queued by the driver, checked by a monitor.
module tb_pipe_hazard_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [14:0]   inst_ID = '0;
  logic [9:0]    inst_EX = '0;
  logic          br_taken_EX = 1'b0, dmem_req_MA = 1'b0, dmem_ready = 1'b0, clr_cnt = 1'b0;
  logic          stall_IF, stall_ID, flush_ID, bubble_EX, stall_EX, stall_MA, bubble_WB;
  logic          mem_timeout;
  logic [CW-1:0] lu_stall_cnt, br_flush_cnt, mem_wait_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RST_HOLD(2), .MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .inst_ID(inst_ID), .inst_EX(inst_EX),
    .br_taken_EX(br_taken_EX), .dmem_req_MA(dmem_req_MA), .dmem_ready(dmem_ready),
    .clr_cnt(clr_cnt), .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID(flush_ID),
    .bubble_EX(bubble_EX), .stall_EX(stall_EX), .stall_MA(stall_MA), .bubble_WB(bubble_WB),
    .mem_timeout(mem_timeout), .lu_stall_cnt(lu_stall_cnt), .br_flush_cnt(br_flush_cnt),
    .mem_wait_cnt(mem_wait_cnt));

  // ctl = {stall_IF, stall_ID, flush_ID, bubble_EX, stall_EX, stall_MA, bubble_WB}
  localparam logic [6:0] C_0    = 7'b0000000;
  localparam logic [6:0] C_HOLD = 7'b1011000;
  localparam logic [6:0] C_LU   = 7'b1101000;
  localparam logic [6:0] C_BR   = 7'b0011000;
  localparam logic [6:0] C_FRZ  = 7'b1100111;

  // Instruction fields: ID = {rs2, rs1, op}, EX = {rd, op}
  localparam logic [14:0] ID_ADD_5_6  = {5'd6, 5'd5, 5'b01100};
  localparam logic [14:0] ID_ADD_0_6  = {5'd6, 5'd0, 5'b01100};
  localparam logic [14:0] ID_ADDI_5   = {5'd6, 5'd5, 5'b00100};
  localparam logic [14:0] ID_JAL      = {5'd5, 5'd5, 5'b11011};
  localparam logic [14:0] ID_IDLE     = {5'd0, 5'd0, 5'b00100};
  localparam logic [9:0]  EX_LW5      = {5'd5, 5'b00000};
  localparam logic [9:0]  EX_LW6      = {5'd6, 5'b00000};
  localparam logic [9:0]  EX_LW0      = {5'd0, 5'b00000};
  localparam logic [9:0]  EX_NOP      = {5'd0, 5'b00100};

  typedef struct {
    string         nm;
    logic [6:0]    ctl;
    logic [CW-1:0] lu, br, mw;
    logic          to;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic apply(input logic rst, input logic [14:0] id, input logic [9:0] ex,
                       input logic br, input logic req, input logic rdy, input logic clr,
                       input logic [6:0] ctl, input int lu, input int brc, input int mw,
                       input logic to, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = rst; inst_ID = id; inst_EX = ex; br_taken_EX = br;
    dmem_req_MA = req; dmem_ready = rdy; clr_cnt = clr;
    e.nm = nm; e.ctl = ctl; e.lu = CW'(lu); e.br = CW'(brc); e.mw = CW'(mw); e.to = to;
    q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a full output set for the queued vector.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {stall_IF, stall_ID, flush_ID, bubble_EX, stall_EX, stall_MA, bubble_WB};
        n_vec++;
        if (act !== e.ctl || lu_stall_cnt !== e.lu || br_flush_cnt !== e.br ||
            mem_wait_cnt !== e.mw || mem_timeout !== e.to) begin
          n_bad++;
          $display("FAIL %s: got ctl=%b lu=%0d br=%0d mw=%0d to=%b, want ctl=%b lu=%0d br=%0d mw=%0d to=%b",
                   e.nm, act, lu_stall_cnt, br_flush_cnt, mem_wait_cnt, mem_timeout,
                   e.ctl, e.lu, e.br, e.mw, e.to);
        end
      end
    end
  end

  initial begin
    // Reset and post-reset hold; load-use inputs present but must not count.
    apply(0, ID_IDLE,    EX_NOP, 0,0,0,0, C_HOLD, 0,0,0, 0, "reset0");
    apply(0, ID_IDLE,    EX_NOP, 0,0,0,0, C_HOLD, 0,0,0, 0, "reset1");
    apply(1, ID_ADD_5_6, EX_LW5, 0,0,0,0, C_HOLD, 0,0,0, 0, "hold1");
    apply(1, ID_ADD_5_6, EX_LW5, 0,0,0,0, C_HOLD, 0,0,0, 0, "hold2");
    // Load-use detection
    apply(1, ID_ADD_5_6, EX_LW5, 0,0,0,0, C_LU,   0,0,0, 0, "lu_rs1");
    apply(1, ID_ADD_5_6, EX_NOP, 0,0,0,0, C_0,    1,0,0, 0, "lu_gone");
    apply(1, ID_ADD_0_6, EX_LW0, 0,0,0,0, C_0,    1,0,0, 0, "lu_rd0");
    apply(1, ID_ADD_5_6, EX_LW6, 0,0,0,0, C_LU,   1,0,0, 0, "lu_rs2");
    apply(1, ID_ADDI_5,  EX_LW6, 0,0,0,0, C_0,    2,0,0, 0, "lu_itype_rs2");
    apply(1, ID_JAL,     EX_LW5, 0,0,0,0, C_0,    2,0,0, 0, "lu_jal");
    // Branch beats load-use
    apply(1, ID_ADD_5_6, EX_LW5, 1,0,0,0, C_BR,   2,0,0, 0, "br_vs_lu");
    apply(1, ID_IDLE,    EX_NOP, 0,0,0,0, C_0,    2,1,0, 0, "after_br");
    // Memory freeze: 3 wait cycles then release
    apply(1, ID_ADD_5_6, EX_LW5, 1,1,0,0, C_FRZ,  2,1,0, 0, "frz1");
    apply(1, ID_IDLE,    EX_NOP, 0,1,0,0, C_FRZ,  2,1,1, 0, "frz2");
    apply(1, ID_IDLE,    EX_NOP, 0,1,0,0, C_FRZ,  2,1,2, 0, "frz3");
    apply(1, ID_IDLE,    EX_NOP, 0,1,1,0, C_0,    2,1,3, 0, "frz_release");
    apply(1, ID_IDLE,    EX_NOP, 0,0,0,0, C_0,    2,1,3, 0, "post_release");
    // Timeout after the 4th consecutive wait cycle
    apply(1, ID_IDLE,    EX_NOP, 0,1,0,0, C_FRZ,  2,1,3, 0, "to_w1");
    apply(1, ID_IDLE,    EX_NOP, 0,1,0,0, C_FRZ,  2,1,4, 0, "to_w2");
    apply(1, ID_IDLE,    EX_NOP, 0,1,0,0, C_FRZ,  2,1,5, 0, "to_w3");
    apply(1, ID_IDLE,    EX_NOP, 0,1,0,0, C_FRZ,  2,1,6, 0, "to_w4");
    apply(1, ID_IDLE,    EX_NOP, 0,1,0,0, C_FRZ,  2,1,7, 1, "to_w5");
    apply(1, ID_IDLE,    EX_NOP, 0,1,0,0, C_FRZ,  2,1,7, 1, "to_w6");
    apply(1, ID_IDLE,    EX_NOP, 0,0,0,0, C_0,    2,1,7, 1, "to_sticky");
    apply(1, ID_IDLE,    EX_NOP, 0,0,0,1, C_0,    2,1,7, 1, "clr_pulse");
    apply(1, ID_IDLE,    EX_NOP, 0,0,0,0, C_0,    0,0,0, 0, "after_clr");
    // Saturation of a 3-bit counter over 9 load-use stalls
    for (int i = 0; i < 9; i++)
      apply(1, ID_ADD_5_6, EX_LW5, 0,0,0,0, C_LU, (i > 7) ? 7 : i, 0,0, 0, "lu_sat");
    apply(1, ID_IDLE,    EX_NOP, 0,0,0,0, C_0,    7,0,0, 0, "sat_hold");
    // Clear has priority over a simultaneous increment
    apply(1, ID_ADD_5_6, EX_LW5, 0,0,0,1, C_LU,   7,0,0, 0, "clr_vs_inc");
    apply(1, ID_IDLE,    EX_NOP, 0,0,0,0, C_0,    0,0,0, 0, "clr_won");
    // Reset mid-run returns to HOLD and clears everything
    apply(1, ID_ADD_5_6, EX_LW5, 0,0,0,0, C_LU,   0,0,0, 0, "pre_rst");
    apply(0, ID_ADD_5_6, EX_LW5, 0,0,0,0, C_HOLD, 0,0,0, 0, "rst_again");

    @(negedge clk);
    #3;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
